// File: rtl/q2a03_oam_dma_if.sv
// CPU-side and DMA-side bus signals of the 2A03 OAM DMA unit.
// The slave modport is the DMA block; the master modport is the core and bus mux side.
interface q2a03_oam_dma_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          G_phy2;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_rdwr;
  logic [DW-1:0] G_rd_data;
  logic          G_ready;
  logic          dma_active;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wr_data;
  logic          dma_rdwr;

  modport master (
    output G_phy2, cpu_addr, cpu_wr_data, cpu_rdwr, G_rd_data,
    input  G_ready, dma_active, dma_addr, dma_wr_data, dma_rdwr
  );

  modport slave (
    input  G_phy2, cpu_addr, cpu_wr_data, cpu_rdwr, G_rd_data,
    output G_ready, dma_active, dma_addr, dma_wr_data, dma_rdwr
  );
endinterface

// File: rtl/q2a03_oam_dma.sv
// 2A03 sprite DMA: a write to $4014 stalls the CPU and copies page XX00-XXFF to $2004,
// with each read placed on a get cycle and each write on the following put cycle.
module q2a03_oam_dma (
  input  logic               G_clock,
  input  logic               G_reset,
  q2a03_oam_dma_if.slave     bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] DMA_REG_ADDR = 16'h4014;
  localparam logic [AW-1:0] OAM_DATA_ADDR = 16'h2004;
  localparam logic [DW-1:0] LAST_INDEX = 8'hff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e        state_q, state_d;
  logic          parity_q, parity_d;
  logic          phy2_q;
  logic [DW-1:0] page_q, page_d;
  logic [DW-1:0] index_q, index_d;
  logic [DW-1:0] data_q, data_d;
  logic          ready_q, ready_d;
  logic          active_q, active_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rdwr_q, rdwr_d;
  logic          cyc_end;

  assign cyc_end = phy2_q & ~bus.G_phy2;

  // Phase-2 edge detector runs every clock; everything else advances only at bus-cycle end.
  always_ff @(posedge G_clock or posedge G_reset) begin
    if (G_reset) begin
      phy2_q <= 1'b0;
    end else begin
      phy2_q <= bus.G_phy2;
    end
  end

  always_ff @(posedge G_clock or posedge G_reset) begin
    if (G_reset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= '0;
      index_q  <= '0;
      data_q   <= '0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdwr_q   <= 1'b1;
    end else if (cyc_end) begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdwr_q   <= rdwr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    parity_d = ~parity_q;
    page_d   = page_q;
    index_d  = index_q;
    data_d   = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_addr == DMA_REG_ADDR && !bus.cpu_rdwr) begin
          page_d  = bus.cpu_wr_data;
          index_d = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // The core only stalls on a read; an odd ending cycle means the next one is a get.
        if (bus.cpu_rdwr) begin
          state_d = parity_q ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        data_d  = bus.G_rd_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        index_d = index_q + DW'(1);
        state_d = (index_q == LAST_INDEX) ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    ready_d  = (state_d == S_IDLE);
    active_d = (state_d == S_READ) || (state_d == S_WRITE);
    rdwr_d   = (state_d != S_WRITE);
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (state_d == S_READ) begin
      addr_d = {page_d, index_d};
    end else if (state_d == S_WRITE) begin
      addr_d  = OAM_DATA_ADDR;
      wdata_d = data_d;
    end
  end

  assign bus.G_ready     = ready_q;
  assign bus.dma_active  = active_q;
  assign bus.dma_addr    = addr_q;
  assign bus.dma_wr_data = wdata_q;
  assign bus.dma_rdwr    = rdwr_q;

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Bench for q2a03_oam_dma: drives CPU bus cycles, predicts every DMA bus cycle into a
// queue and compares each DMA-active cycle and the stall length against it.
module tb_q2a03_oam_dma;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic G_clock;
  logic G_reset;

  q2a03_oam_dma_if bus ();

  q2a03_oam_dma dut (
    .G_clock (G_clock),
    .G_reset (G_reset),
    .bus     (bus.slave)
  );

  // Memory behind the DMA: location (page, idx) holds idx ^ 8'h5A.
  assign bus.G_rd_data = bus.dma_addr[7:0] ^ 8'h5A;

  initial G_clock = 1'b0;
  always #5 G_clock = ~G_clock;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_idx  = 0;
  int   low_cnt  = 0;
  exp_t sb[$];

  logic        s_ready, s_act, s_rdwr;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cpu cycle %0d)", tag, act, exp, cyc_idx);
    end
  endtask

  // One CPU bus cycle: phase-2 high for a clock, then low; the cycle ends on the next rising edge.
  task automatic cpu_cyc(input logic [15:0] a, input logic [7:0] d, input logic rw);
    exp_t e;
    @(negedge G_clock);
    bus.cpu_addr    = a;
    bus.cpu_wr_data = d;
    bus.cpu_rdwr    = rw;
    bus.G_phy2      = 1'b1;
    #1;
    s_ready = bus.G_ready;
    s_act   = bus.dma_active;
    s_rdwr  = bus.dma_rdwr;
    s_addr  = bus.dma_addr;
    s_wdata = bus.dma_wr_data;
    if (!s_ready) low_cnt++;
    if (s_act) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_dma", 32'(s_addr), 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        check_eq("dma_rdwr", 32'(s_rdwr), 32'(e.rd));
        check_eq("dma_addr", 32'(s_addr), 32'(e.addr));
        if (!e.rd) check_eq("dma_wr_data", 32'(s_wdata), 32'(e.data));
      end
    end
    @(negedge G_clock);
    bus.G_phy2 = 1'b0;
    cyc_idx++;
  endtask

  task automatic align_to(input int p);
    while ((cyc_idx % 2) != p) cpu_cyc(16'h0000, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    G_reset = 1'b1;
    #1;
    check_eq("rst_ready", 32'(bus.G_ready), 32'd1);
    check_eq("rst_active", 32'(bus.dma_active), 32'd0);
    check_eq("rst_addr", 32'(bus.dma_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus.dma_wr_data), 32'd0);
    check_eq("rst_rdwr", 32'(bus.dma_rdwr), 32'd1);
    bus.G_phy2 = 1'b0;
    repeat (2) @(negedge G_clock);
    G_reset = 1'b0;
    cyc_idx = 0;
    sb.delete();
  endtask

  // Issue a $4014 write, optional extra CPU writes, then reads until the CPU is released.
  task automatic run_dma(input logic [7:0] page, input int pre_wr, input int abort_idx);
    exp_t e;
    int   n;
    int   exp_low;
    logic [7:0] last_idx;
    for (int i = 0; i < 256; i++) begin
      e.rd = 1'b1; e.addr = {page, 8'(i)}; e.data = 8'h00;
      sb.push_back(e);
      e.rd = 1'b0; e.addr = 16'h2004; e.data = 8'(i) ^ 8'h5A;
      sb.push_back(e);
    end
    low_cnt = 0;
    cpu_cyc(16'h4014, page, 1'b0);
    check_eq("idle_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < pre_wr; i++) begin
      cpu_cyc(16'h4014, 8'hEE, 1'b0);
      check_eq("halt_wr_ready", 32'(s_ready), 32'd0);
      check_eq("halt_wr_active", 32'(s_act), 32'd0);
    end
    exp_low  = 1 + pre_wr + (((cyc_idx % 2) == 0) ? 1 : 0) + 512;
    n        = 0;
    last_idx = 8'h00;
    do begin
      cpu_cyc(16'hFFFE, 8'h00, 1'b1);
      if (n == 0) check_eq("ready_drop", 32'(s_ready), 32'd0);
      n++;
      if (s_act && s_rdwr) last_idx = s_addr[7:0];
      if (abort_idx >= 0 && s_act && !s_rdwr && last_idx == 8'(abort_idx)) begin
        do_reset();
        return;
      end
    end while (!s_ready && n < 600);
    if (n >= 600) check_eq("timeout_ready", 32'(s_ready), 32'd1);
    check_eq("ready_low_cycles", 32'(low_cnt), 32'(exp_low));
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("released_active", 32'(s_act), 32'd0);
  endtask

  initial begin
    G_reset         = 1'b1;
    bus.G_phy2      = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_wr_data = 8'h00;
    bus.cpu_rdwr    = 1'b1;
    repeat (2) @(negedge G_clock);
    do_reset();

    // Stall length with and without the alignment cycle.
    align_to(0);
    run_dma(8'h02, 0, -1);
    align_to(1);
    run_dma(8'h02, 0, -1);

    // CPU keeps writing while halted (also ignored $4014 writes); page 7 data pattern.
    align_to(0);
    run_dma(8'h07, 2, -1);
    align_to(1);
    run_dma(8'h07, 1, -1);

    // Accesses that must not start a transfer.
    cpu_cyc(16'h4015, 8'h12, 1'b0);
    cpu_cyc(16'h4013, 8'h34, 1'b0);
    check_eq("ign_4015_ready", 32'(s_ready), 32'd1);
    cpu_cyc(16'h4014, 8'h00, 1'b1);
    check_eq("ign_4013_ready", 32'(s_ready), 32'd1);
    cpu_cyc(16'h0000, 8'h00, 1'b1);
    check_eq("ign_rd4014_ready", 32'(s_ready), 32'd1);
    check_eq("ign_rd4014_active", 32'(s_act), 32'd0);

    // Abort mid-transfer, then a fresh transfer must start at index 0.
    run_dma(8'h03, 0, 8'h40);
    cpu_cyc(16'h0000, 8'h00, 1'b1);
    check_eq("post_abort_ready", 32'(s_ready), 32'd1);
    run_dma(8'h03, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
